// File: rtl/sm4_key_expand_if.sv
`default_nettype none
// ============================================================================
// Module   : sm4_key_expand_if
// Brief    : Master-key handshake and round-key stream bundle for the SM4
//            key schedule.
// Revision : 1.0 - initial release
// ============================================================================
interface sm4_key_expand_if;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         rk_valid;
    logic [4:0]   rk_idx;
    logic [31:0]  rk_out;
    logic         done;

    modport master (
        output key_valid, key_in,
        input  key_ready, rk_valid, rk_idx, rk_out, done
    );

    modport slave (
        input  key_valid, key_in,
        output key_ready, rk_valid, rk_idx, rk_out, done
    );
endinterface
`default_nettype wire

// File: rtl/sm4_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : transform / sm4_key_expand
// Brief    : SM4 mixer T (k_f=0) or T' (k_f=1), and the iterative key
//            schedule producing rk0..rk31 one per clock.
// Revision : 1.0 - initial release
// ============================================================================
module transform (
    input  logic [31:0] din,
    input  logic        k_f,
    output logic [31:0] dout
);
    // Entry 0 sits in the top byte, so entry b lives at bit {~b, 3'b111}.
    localparam logic [2047:0] C_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic [31:0] w_b;
    logic [31:0] w_l_key;
    logic [31:0] w_l_enc;

    generate
        for (genvar j = 0; j < 4; j++) begin : g_sbox
            assign w_b[8*j +: 8] = C_SBOX[{~din[8*j +: 8], 3'b111} -: 8];
        end
    endgenerate

    assign w_l_key = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
    assign w_l_enc = w_b ^ {w_b[29:0], w_b[31:30]} ^ {w_b[21:0], w_b[31:22]}
                   ^ {w_b[13:0], w_b[31:14]} ^ {w_b[7:0], w_b[31:8]};
    assign dout    = k_f ? w_l_key : w_l_enc;
endmodule

module sm4_key_expand (
    input  logic                    clk,
    input  logic                    rst_n,
    sm4_key_expand_if.slave         kif
);
    localparam logic [31:0] C_FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] C_FK1 = 32'h56AA3350;
    localparam logic [31:0] C_FK2 = 32'h677D9197;
    localparam logic [31:0] C_FK3 = 32'hB27022DC;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;
    logic [4:0]  r_cnt;
    logic [31:0] r_k0, r_k1, r_k2, r_k3;
    logic [31:0] r_rk_out;
    logic [4:0]  r_rk_idx;
    logic        r_rk_valid;
    logic        r_done;
    logic        w_load;
    logic        w_step;
    logic [7:0]  w_ck_base;
    logic [31:0] w_ck;
    logic [31:0] w_t_in;
    logic [31:0] w_t_out;
    logic [31:0] w_rk;

    // r_ready is held low for the first edge after reset release, so a
    // key_valid asserted during reset cannot be taken on that edge.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (kif.key_valid && r_ready) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == 5'd31) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // CK byte j = 28*i + 7*j, wrapping naturally in 8 bits.
    assign w_ck_base = {3'b000, r_cnt} * 8'd28;

    generate
        for (genvar j = 0; j < 4; j++) begin : g_ck
            assign w_ck[31-8*j -: 8] = w_ck_base + 8'(7 * j);
        end
    endgenerate

    assign w_t_in = r_k1 ^ r_k2 ^ r_k3 ^ w_ck;

    transform u_tprime (
        .din  (w_t_in),
        .k_f  (1'b1),
        .dout (w_t_out)
    );

    assign w_rk = r_k0 ^ w_t_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_cnt      <= 5'd0;
            r_k0       <= 32'd0;
            r_k1       <= 32'd0;
            r_k2       <= 32'd0;
            r_k3       <= 32'd0;
            r_rk_out   <= 32'd0;
            r_rk_idx   <= 5'd0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ready    <= (w_state_next == S_IDLE);
            r_rk_valid <= w_step;
            r_done     <= w_step && (r_cnt == 5'd31);
            if (w_load) begin
                r_k0  <= kif.key_in[127:96] ^ C_FK0;
                r_k1  <= kif.key_in[95:64]  ^ C_FK1;
                r_k2  <= kif.key_in[63:32]  ^ C_FK2;
                r_k3  <= kif.key_in[31:0]   ^ C_FK3;
                r_cnt <= 5'd0;
            end else if (w_step) begin
                r_k0     <= r_k1;
                r_k1     <= r_k2;
                r_k2     <= r_k3;
                r_k3     <= w_rk;
                r_rk_out <= w_rk;
                r_rk_idx <= r_cnt;
                r_cnt    <= r_cnt + 5'd1;
            end
        end
    end

    assign kif.key_ready = r_ready;
    assign kif.rk_valid  = r_rk_valid;
    assign kif.rk_idx    = r_rk_idx;
    assign kif.rk_out    = r_rk_out;
    assign kif.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_sm4_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm4_key_expand
// Brief    : Self-checking bench for the SM4 key schedule against a word-level
//            reference of the standard K[i+4] recurrence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm4_key_expand;
    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [2047:0] SBOX_P = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sm4_key_expand_if kif();

    sm4_key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  sbox [256];
    logic [31:0] exp_rk [32];
    logic        cap_valid [$];
    logic [4:0]  cap_idx   [$];
    logic [31:0] cap_rk    [$];
    logic        cap_done  [$];
    logic        cap_ready [$];

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ck_word(input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'((28 * i + 7 * j) % 256);
        return w;
    endfunction

    function automatic logic [31:0] t_prime(input logic [31:0] a);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox[a[8*j +: 8]];
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    task automatic build_model(input logic [127:0] mk);
        logic [31:0] k  [36];
        logic [31:0] fk [4];
        fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350;
        fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            k[i+4]    = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i));
            exp_rk[i] = k[i+4];
        end
    endtask

    task automatic clear_cap();
        cap_valid.delete(); cap_idx.delete(); cap_rk.delete();
        cap_done.delete();  cap_ready.delete();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cap_valid.push_back(kif.rk_valid);
        cap_idx.push_back(kif.rk_idx);
        cap_rk.push_back(kif.rk_out);
        cap_done.push_back(kif.done);
        cap_ready.push_back(kif.key_ready);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_in    = '0;
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        clear_cap();
    endtask

    // Handshake at E0, then capture ncap cycles; capture c follows edge E(c+1).
    task automatic run_job(input logic [127:0] mk, input int ncap);
        do_reset();
        build_model(mk);
        kif.key_in    = mk;
        kif.key_valid = 1'b1;
        cycle();
        kif.key_valid = 1'b0;
        clear_cap();
        repeat (ncap) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        kif.key_valid = 1'b1;
        kif.key_in    = STD_KEY;
        clear_cap();
        repeat (3) cycle();
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({cap_valid[c], cap_idx[c], cap_rk[c], cap_done[c], cap_ready[c]} !== 40'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got v=%b idx=%0d rk=%h done=%b rdy=%b, expected all 0",
                         c, cap_valid[c], cap_idx[c], cap_rk[c], cap_done[c], cap_ready[c]);
            end
        end
        rst_n = 1'b1;
        clear_cap();
        cycle();
        n_tests++;
        if (cap_ready[0] !== 1'b1 || cap_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b v=%b, expected rdy=1 v=0", cap_ready[0], cap_valid[0]);
        end
        cycle();
        kif.key_valid = 1'b0;
        n_tests++;
        if (cap_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got rdy=%b, expected 0", cap_ready[1]);
        end
        cycle();
        n_tests++;
        if (cap_valid[2] !== 1'b1 || cap_idx[2] !== 5'd0 || cap_rk[2] !== 32'hF12186F9) begin
            n_fail++;
            $display("FAIL reset_first_rk: got v=%b idx=%0d rk=%h, expected v=1 idx=0 rk=f12186f9",
                     cap_valid[2], cap_idx[2], cap_rk[2]);
        end
    endtask

    task automatic test_standard();
        int nv;
        run_job(STD_KEY, 34);
        nv = 0;
        for (int c = 0; c < 34; c++) if (cap_valid[c] === 1'b1) nv++;
        n_tests++;
        if (nv !== 32) begin
            n_fail++;
            $display("FAIL std_valid_count: got %0d, expected 32", nv);
        end
        for (int c = 0; c < 32; c++) begin
            n_tests++;
            if (cap_valid[c] !== 1'b1 || cap_idx[c] !== 5'(c) || cap_rk[c] !== exp_rk[c]) begin
                n_fail++;
                $display("FAIL std_rk[%0d]: got v=%b idx=%0d rk=%h, expected v=1 idx=%0d rk=%h",
                         c, cap_valid[c], cap_idx[c], cap_rk[c], c, exp_rk[c]);
            end
        end
        for (int c = 0; c < 34; c++) begin
            n_tests++;
            if (cap_done[c] !== (c == 31)) begin
                n_fail++;
                $display("FAIL std_done[%0d]: got %b, expected %b", c, cap_done[c], (c == 31));
            end
        end
        n_tests++;
        if (cap_rk[0] !== 32'hF12186F9 || cap_rk[1] !== 32'h41662B61 || cap_rk[31] !== 32'h9124A012) begin
            n_fail++;
            $display("FAIL std_golden: got %h %h %h, expected f12186f9 41662b61 9124a012",
                     cap_rk[0], cap_rk[1], cap_rk[31]);
        end
        n_tests++;
        if (cap_ready[30] !== 1'b0 || cap_ready[31] !== 1'b1) begin
            n_fail++;
            $display("FAIL std_ready: got %b %b, expected 0 1", cap_ready[30], cap_ready[31]);
        end
    endtask

    task automatic test_busy();
        do_reset();
        build_model(STD_KEY);
        kif.key_in    = STD_KEY;
        kif.key_valid = 1'b1;
        cycle();
        clear_cap();
        for (int k = 1; k <= 34; k++) begin
            if (k == 5 || k == 20) begin
                kif.key_valid = 1'b1;
                kif.key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
                n_tests++;
                if (kif.key_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_ready_E%0d: got %b, expected 0", k, kif.key_ready);
                end
            end else begin
                kif.key_valid = 1'b0;
            end
            cycle();
        end
        kif.key_valid = 1'b0;
        for (int c = 0; c < 32; c++) begin
            n_tests++;
            if (cap_valid[c] !== 1'b1 || cap_rk[c] !== exp_rk[c]) begin
                n_fail++;
                $display("FAIL busy_rk[%0d]: got v=%b rk=%h, expected v=1 rk=%h", c, cap_valid[c], cap_rk[c], exp_rk[c]);
            end
        end
        n_tests++;
        if (cap_rk[31] !== 32'h9124A012 || cap_done[31] !== 1'b1 || cap_valid[32] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_end: got rk=%h done=%b next_v=%b, expected rk=9124a012 done=1 next_v=0",
                     cap_rk[31], cap_done[31], cap_valid[32]);
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        do_reset();
        build_model(STD_KEY);
        kif.key_in    = STD_KEY;
        kif.key_valid = 1'b1;
        cycle();
        clear_cap();
        repeat (66) cycle();
        kif.key_valid = 1'b0;
        nv = 0;
        for (int c = 0; c < 66; c++) if (cap_valid[c] === 1'b1) nv++;
        n_tests++;
        if (nv !== 64) begin
            n_fail++;
            $display("FAIL b2b_valid_count: got %0d, expected 64", nv);
        end
        n_tests++;
        if (cap_ready[31] !== 1'b1 || cap_ready[32] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_handshake_E33: got rdy %b %b, expected 1 0", cap_ready[31], cap_ready[32]);
        end
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (cap_valid[33+i] !== 1'b1 || cap_idx[33+i] !== 5'(i) || cap_rk[33+i] !== exp_rk[i]) begin
                n_fail++;
                $display("FAIL b2b_rk2[%0d]: got v=%b idx=%0d rk=%h, expected v=1 idx=%0d rk=%h",
                         i, cap_valid[33+i], cap_idx[33+i], cap_rk[33+i], i, exp_rk[i]);
            end
        end
        n_tests++;
        if (cap_rk[33] !== 32'hF12186F9 || cap_done[64] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_job: got rk0=%h done=%b, expected f12186f9 1", cap_rk[33], cap_done[64]);
        end
    endtask

    task automatic test_midrun_reset();
        bit found;
        run_job(STD_KEY, 0);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            cycle();
            if (cap_valid[$] === 1'b1 && cap_idx[$] === 5'd10) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midrun_reach_idx10: got none within 40 cycles, expected rk_idx=10");
        end
        rst_n = 1'b0;
        clear_cap();
        repeat (3) cycle();
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (cap_valid[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_valid[%0d]: got %b, expected 0", c, cap_valid[c]);
            end
        end
        rst_n = 1'b1;
        cycle();
        kif.key_in    = STD_KEY;
        kif.key_valid = 1'b1;
        cycle();
        kif.key_valid = 1'b0;
        clear_cap();
        cycle(); cycle();
        n_tests++;
        if (cap_valid[0] !== 1'b1 || cap_idx[0] !== 5'd0 || cap_rk[0] !== 32'hF12186F9
            || cap_rk[1] !== 32'h41662B61) begin
            n_fail++;
            $display("FAIL midrun_restart: got v=%b idx=%0d rk0=%h rk1=%h, expected 1 0 f12186f9 41662b61",
                     cap_valid[0], cap_idx[0], cap_rk[0], cap_rk[1]);
        end
    endtask

    task automatic test_keys();
        logic [127:0] mk;
        for (int n = 0; n < 5; n++) begin
            mk = (n == 0) ? 128'd0 : {$urandom(), $urandom(), $urandom(), $urandom()};
            run_job(mk, 33);
            for (int c = 0; c < 32; c++) begin
                n_tests++;
                if (cap_valid[c] !== 1'b1 || cap_idx[c] !== 5'(c) || cap_rk[c] !== exp_rk[c]) begin
                    n_fail++;
                    $display("FAIL key%0d_rk[%0d]: mk=%h got v=%b idx=%0d rk=%h, expected rk=%h",
                             n, c, mk, cap_valid[c], cap_idx[c], cap_rk[c], exp_rk[c]);
                end
            end
            n_tests++;
            if (cap_valid[32] !== 1'b0) begin
                n_fail++;
                $display("FAIL key%0d_stop: got v=%b after rk31, expected 0", n, cap_valid[32]);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_in    = '0;
        for (int i = 0; i < 256; i++) sbox[i] = SBOX_P[2047 - 8*i -: 8];
        test_reset();
        test_standard();
        test_busy();
        test_back_to_back();
        test_midrun_reset();
        test_keys();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
